// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: core request/response and data-memory signals of the load/store unit
interface lsu_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_read, mem_write, mem_addr, mem_wdata
    );
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store unit driving a word-only single-port data memory
module lsu_mem_initiator #(
    parameter int DEPTH_WORDS = 256
) (
    input logic                 clk,
    input logic                 rst_n,
    lsu_mem_initiator_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
    state_t      state, state_n;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
    logic        fault_q;
    logic        hs, illegal, misaligned, out_of_range, fault;
    logic [4:0]  sh;
    logic [15:0] sel;
    logic [31:0] mask, ins, merge_d, ext;
    // request acceptance and fault classification from the live request
    always_comb begin
        hs           = bus.req_valid && state == IDLE;
        illegal      = bus.req_we ? !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                  : (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
        misaligned   = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        out_of_range = bus.req_addr >= LIMIT;
        fault        = illegal || misaligned || out_of_range;
    end
    // lane select, sub-word merge for stores and extension for loads
    always_comb begin
        sh      = f3_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
        mask    = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        ins     = (f3_q[0] ? {16'h0, wdata_q[15:0]} : {24'h0, wdata_q[7:0]}) << sh;
        merge_d = (bus.mem_rdata & ~mask) | ins;
        sel     = 16'(bus.mem_rdata >> sh);
        ext     = f3_q[1] ? bus.mem_rdata
                : f3_q[0] ? {{16{sel[15] & ~f3_q[2]}}, sel}
                :           {{24{sel[7] & ~f3_q[2]}}, sel[7:0]};
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // next-state: faults respond at once, SW skips the read half of read-modify-write
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !hs ? IDLE : fault ? RESP : !bus.req_we ? LOAD
                             : bus.req_funct3[1] ? WRITE : RMW_RD;
            LOAD:    state_n = RESP;
            RMW_RD:  state_n = WRITE;
            WRITE:   state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // latch the request on handshake and the merge word during the read phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
        end else begin
            if (hs) begin
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == RMW_RD) merge_q <= merge_d;
        end
    end
    // response data and fault update only on entry to RESP so they hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else if (state_n == RESP && state != RESP) begin
            fault_q <= state == IDLE;
            rdata_q <= state == LOAD ? ext : '0;
        end
    end
    // outputs decode from state so reset clears the memory strobes immediately
    always_comb begin
        bus.req_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
        bus.rsp_fault = fault_q;
        bus.rsp_rdata = rdata_q;
        bus.mem_read  = state == LOAD || state == RMW_RD;
        bus.mem_write = state == WRITE;
        bus.mem_addr  = (state == LOAD || state == RMW_RD || state == WRITE)
                      ? {addr_q[31:2], 2'b00} : '0;
        bus.mem_wdata = state == WRITE ? (f3_q[1] ? wdata_q : merge_q) : '0;
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: scoreboard bench with a word memory model behind the unit
module tb_lsu_mem_initiator;
    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          due;
        string       name;
    } exp_t;
    logic clk, rst_n;
    int tests = 0, fails = 0, cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rsp_cnt = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    logic [31:0] mem [256];
    exp_t sb[$];
    lsu_mem_initiator_if bus();
    lsu_mem_initiator #(.DEPTH_WORDS(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    // memory-side activity log, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            rd_cnt   <= rd_cnt + int'(bus.mem_read);
            wr_cnt   <= wr_cnt + int'(bus.mem_write);
            both_cnt <= both_cnt + int'(bus.mem_read && bus.mem_write);
            rsp_cnt  <= rsp_cnt + int'(bus.rsp_valid);
            if (bus.mem_write) begin
                last_waddr <= bus.mem_addr;
                last_wdata <= bus.mem_wdata;
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, wdata,
                        input logic [31:0] er, input logic ef, input int lat, input string nm);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            tests++; fails++;
            $display("FAIL %s accept: req_ready stayed low", nm);
        end
        sb.push_back('{er, ef, cyc + lat, nm});
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic ok, output logic [31:0] rd, output logic f, output int at);
        int n = 0;
        while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
        ok = bus.rsp_valid; rd = bus.rsp_rdata; f = bus.rsp_fault; at = cyc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.mem_read, bus.mem_write} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 10000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.mem_read, bus.mem_write});
        end
        tests++;
        if (bus.rsp_rdata !== 0 || bus.mem_addr !== 0 || bus.mem_wdata !== 0) begin
            fails++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", bus.rsp_rdata, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_sw();
        exp_t e; logic ok, f; logic [31:0] rd; int at, r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_0x10");
        get_rsp(ok, rd, f, at); e = sb.pop_front();
        tests++;
        if (!ok || rd !== e.rdata || f !== e.fault || at !== e.due) begin
            fails++;
            $display("FAIL %s: valid=%0b rdata=%h fault=%0b cyc=%0d want rdata=%h fault=%0b cyc=%0d",
                     e.name, ok, rd, f, at, e.rdata, e.fault, e.due);
        end
        tests++;
        if (wr_cnt - w0 != 1 || rd_cnt - r0 != 0 || last_waddr !== 32'h10 || last_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL sw_mem: writes=%0d reads=%0d addr=%h data=%h want 1 0 00000010 deadbeef",
                     wr_cnt - w0, rd_cnt - r0, last_waddr, last_wdata);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] ads [6] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] exs [6] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE,
                                 32'hFFFFDEAD, 32'h0000BEEF, 32'hFFFFFFEF};
        for (int i = 0; i < 6; i++) begin
            exp_t e; logic ok, f; logic [31:0] rd; int at, r0, w0;
            r0 = rd_cnt; w0 = wr_cnt;
            send(1'b0, f3s[i], ads[i], 32'h0, exs[i], 1'b0, 2, $sformatf("load%0d", i));
            get_rsp(ok, rd, f, at); e = sb.pop_front();
            tests++;
            if (!ok || rd !== e.rdata || f !== e.fault || at !== e.due || rd_cnt - r0 != 1 || wr_cnt != w0) begin
                fails++;
                $display("FAIL %s: valid=%0b rdata=%h fault=%0b cyc=%0d reads=%0d want rdata=%h fault=%0b cyc=%0d reads=1",
                         e.name, ok, rd, f, at, rd_cnt - r0, e.rdata, e.fault, e.due);
            end
        end
    endtask

    task automatic test_rmw();
        logic [2:0]  f3s [2] = '{3'b000, 3'b001};
        logic [31:0] ads [2] = '{32'h11, 32'h12};
        logic [31:0] wds [2] = '{32'h12345677, 32'h0000CAFE};
        logic [31:0] wrd [2] = '{32'hDEAD77EF, 32'hCAFE77EF};
        for (int i = 0; i < 2; i++) begin
            exp_t e; logic ok, f; logic [31:0] rd; int at, r0, w0;
            r0 = rd_cnt; w0 = wr_cnt;
            send(1'b1, f3s[i], ads[i], wds[i], 32'h0, 1'b0, 3, $sformatf("rmw%0d", i));
            get_rsp(ok, rd, f, at); e = sb.pop_front();
            tests++;
            if (!ok || rd !== e.rdata || f !== e.fault || at !== e.due) begin
                fails++;
                $display("FAIL %s: valid=%0b rdata=%h fault=%0b cyc=%0d want rdata=%h fault=%0b cyc=%0d",
                         e.name, ok, rd, f, at, e.rdata, e.fault, e.due);
            end
            tests++;
            if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1 || last_waddr !== 32'h10 || last_wdata !== wrd[i]) begin
                fails++;
                $display("FAIL %s_mem: reads=%0d writes=%0d addr=%h data=%h want 1 1 00000010 %h",
                         e.name, rd_cnt - r0, wr_cnt - w0, last_waddr, last_wdata, wrd[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic        wes [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ads [6] = '{32'h12, 32'h11, 32'h13, 32'h400, 32'h10, 32'h10};
        for (int i = 0; i < 6; i++) begin
            exp_t e; logic ok, f; logic [31:0] rd; int at, r0, w0;
            r0 = rd_cnt; w0 = wr_cnt;
            send(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, 32'h0, 1'b1, 1, $sformatf("fault%0d", i));
            get_rsp(ok, rd, f, at); e = sb.pop_front();
            tests++;
            if (!ok || rd !== e.rdata || f !== e.fault || at !== e.due || rd_cnt != r0 || wr_cnt != w0) begin
                fails++;
                $display("FAIL %s: valid=%0b rdata=%h fault=%0b cyc=%0d reads=%0d writes=%0d want fault=1 cyc=%0d no access",
                         e.name, ok, rd, f, at, rd_cnt - r0, wr_cnt - w0, e.due);
            end
        end
        tests++;
        if (mem[4] !== 32'hCAFE77EF) begin
            fails++;
            $display("FAIL fault_mem: word 0x10=%h want cafe77ef", mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        logic        wes [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'b010, 3'b010, 3'b100};
        logic [31:0] ads [3] = '{32'h10, 32'h20, 32'h21};
        logic [31:0] wds [3] = '{32'h0, 32'h11223344, 32'h0};
        logic [31:0] exs [3] = '{32'hCAFE77EF, 32'h0, 32'h00000033};
        int busy_seen = 0, got = 0;
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    int n = 0;
                    bus.req_valid = 1'b1; bus.req_we = wes[i]; bus.req_funct3 = f3s[i];
                    bus.req_addr = ads[i]; bus.req_wdata = wds[i];
                    while (!bus.req_ready && n < 50) begin busy_seen++; @(negedge clk); n++; end
                    sb.push_back('{exs[i], 1'b0, cyc + 2, $sformatf("b2b%0d", i)});
                    @(negedge clk);
                end
                bus.req_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    exp_t e; logic ok, f; logic [31:0] rd; int at;
                    get_rsp(ok, rd, f, at);
                    if (ok) got++;
                    e = sb.size() != 0 ? sb.pop_front() : '{32'hX, 1'bX, -1, "b2b_none"};
                    tests++;
                    if (!ok || rd !== e.rdata || f !== e.fault || at !== e.due) begin
                        fails++;
                        $display("FAIL %s: valid=%0b rdata=%h fault=%0b cyc=%0d want rdata=%h fault=%0b cyc=%0d",
                                 e.name, ok, rd, f, at, e.rdata, e.fault, e.due);
                    end
                end
            end
        join
        tests++;
        if (busy_seen == 0 || got != 3 || sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_flow: busy_cycles=%0d responses=%0d leftover=%0d want >0 3 0", busy_seen, got, sb.size());
        end
    endtask

    task automatic test_reset_mid_write();
        exp_t e; logic ok, f; logic [31:0] rd; int at, n, c0;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h000000AA;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (!bus.mem_write && n < 10) begin @(negedge clk); n++; end
        tests++;
        if (bus.mem_write !== 1'b1) begin
            fails++;
            $display("FAIL rst_reach_write: mem_write=%b want 1", bus.mem_write);
        end
        c0 = rsp_cnt;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_async: mem_write=%b mem_read=%b req_ready=%b want 0 0 1", bus.mem_write, bus.mem_read, bus.req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_cnt != c0 || bus.rsp_valid !== 1'b0 || bus.rsp_fault !== 1'b0 || bus.rsp_rdata !== 0 ||
            bus.mem_addr !== 0 || bus.mem_wdata !== 0 || bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_after: pulses=%0d valid=%b fault=%b rdata=%h addr=%h wdata=%h ready=%b want 0 0 0 0 0 0 1",
                     rsp_cnt - c0, bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata, bus.mem_addr, bus.mem_wdata, bus.req_ready);
        end
        send(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE77EF, 1'b0, 2, "rst_lw");
        get_rsp(ok, rd, f, at); e = sb.pop_front();
        tests++;
        if (!ok || rd !== e.rdata || f !== e.fault || at !== e.due) begin
            fails++;
            $display("FAIL %s: valid=%0b rdata=%h fault=%0b cyc=%0d want rdata=%h fault=%0b cyc=%0d",
                     e.name, ok, rd, f, at, e.rdata, e.fault, e.due);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_sw();
        test_loads();
        test_rmw();
        test_faults();
        test_back_to_back();
        tests++;
        if (both_cnt != 0) begin
            fails++;
            $display("FAIL rd_wr_overlap: cycles=%0d want 0", both_cnt);
        end
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
